// File: rtl/pipe_multi_add.sv
`default_nettype none
// ============================================================================
// Module   : pipe_multi_add
// Summary  : Pipelined ternary adder tree summing NUM_IN operands, one level
//            per register stage, with a global valid/ready stall.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_multi_add #(
    parameter int WIDTH     = 8,
    parameter int NUM_IN    = 9,
    parameter bit SIGN_EXT  = 1'b0,
    localparam int LEVELS    = (NUM_IN <= 3) ? 1 : (NUM_IN <= 9) ? 2 : 3,
    localparam int OUT_WIDTH = WIDTH + 2 * LEVELS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_IN*WIDTH-1:0]   in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [OUT_WIDTH-1:0]      out_sum,
    output logic                      out_valid,
    input  logic                      out_ready
);

    // Number of partial sums produced by a given level (level 0 = operands).
    function automatic int f_count(input int lvl);
        int c;
        c = NUM_IN;
        for (int i = 0; i < lvl; i++) begin
            c = (c + 2) / 3;
        end
        return c;
    endfunction

    logic                 w_advance;
    logic [LEVELS-1:0]    r_valid;
    // Raw node values of every level, zero-padded to OUT_WIDTH; each level
    // only carries meaning in its low WIDTH+2*level bits.
    logic [OUT_WIDTH-1:0] w_node [0:LEVELS][0:NUM_IN-1];

    assign w_advance = out_ready | ~out_valid;
    assign in_ready  = w_advance;
    assign out_valid = r_valid[LEVELS-1];
    assign out_sum   = w_node[LEVELS][0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (w_advance) begin
            r_valid[0] <= in_valid;
            for (int i = 1; i < LEVELS; i++) begin
                r_valid[i] <= r_valid[i-1];
            end
        end
    end

    generate
        for (genvar j = 0; j < NUM_IN; j++) begin : g_operand
            assign w_node[0][j] = OUT_WIDTH'(in_data[j*WIDTH +: WIDTH]);
        end

        for (genvar l = 1; l <= LEVELS; l++) begin : g_level
            localparam int W_IN  = WIDTH + 2 * (l - 1);
            localparam int W_OUT = W_IN + 2;
            localparam int N_IN  = f_count(l - 1);
            localparam int N_OUT = f_count(l);

            // Data registers only capture when the incoming stage is valid,
            // so bubbles leave the previous result in place.
            logic w_load;
            if (l == 1) begin : g_first
                assign w_load = w_advance & in_valid;
            end else begin : g_inner
                assign w_load = w_advance & r_valid[l-2];
            end

            for (genvar j = 0; j < NUM_IN; j++) begin : g_node
                if (j < N_OUT) begin : g_sum
                    logic [W_OUT-1:0] w_opnd [0:2];
                    logic [W_OUT-1:0] r_sum;

                    for (genvar k = 0; k < 3; k++) begin : g_opnd
                        if (3 * j + k < N_IN) begin : g_real
                            logic [W_IN-1:0] w_raw;
                            assign w_raw = w_node[l-1][3*j+k][W_IN-1:0];
                            assign w_opnd[k] = SIGN_EXT ? {{2{w_raw[W_IN-1]}}, w_raw}
                                                        : {2'b00, w_raw};
                        end else begin : g_zero
                            assign w_opnd[k] = '0;
                        end
                    end

                    always_ff @(posedge clk) begin
                        if (rst) begin
                            r_sum <= '0;
                        end else if (w_load) begin
                            r_sum <= w_opnd[0] + w_opnd[1] + w_opnd[2];
                        end
                    end

                    assign w_node[l][j] = OUT_WIDTH'(r_sum);
                end else begin : g_unused
                    assign w_node[l][j] = '0;
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pipe_multi_add.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_multi_add
// Summary  : Scoreboard bench for pipe_multi_add (unsigned, signed, 2-input).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_multi_add;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [71:0] in_data;

    logic        rdy0, ov0, rdy1, ov1, rdy2, ov2;
    logic [11:0] sum0, sum1;
    logic [5:0]  sum2;

    logic [11:0] cur_eu, cur_es;
    logic [5:0]  cur_esm;
    logic [11:0] q0[$];
    logic [11:0] q1[$];
    logic [5:0]  q2[$];

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [7:0]  op;
        logic [11:0] eu;
        logic [11:0] es;
        logic [5:0]  esm;
    } vec_t;
    vec_t tbl[6];

    always #5 clk = ~clk;

    pipe_multi_add #(.WIDTH(8), .NUM_IN(9), .SIGN_EXT(1'b0)) u0 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy0), .out_sum(sum0), .out_valid(ov0), .out_ready(out_ready));

    pipe_multi_add #(.WIDTH(8), .NUM_IN(9), .SIGN_EXT(1'b1)) u1 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy1), .out_sum(sum1), .out_valid(ov1), .out_ready(out_ready));

    pipe_multi_add #(.WIDTH(4), .NUM_IN(2), .SIGN_EXT(1'b0)) u2 (
        .clk(clk), .rst(rst), .in_data(in_data[7:0]), .in_valid(in_valid),
        .in_ready(rdy2), .out_sum(sum2), .out_valid(ov2), .out_ready(out_ready));

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    function automatic logic [11:0] model_u(input logic [71:0] d);
        int s = 0;
        for (int k = 0; k < 9; k++) s += int'(d[k*8 +: 8]);
        return 12'(s);
    endfunction

    function automatic logic [11:0] model_s(input logic [71:0] d);
        int s = 0;
        for (int k = 0; k < 9; k++) s += int'($signed(d[k*8 +: 8]));
        return 12'(s);
    endfunction

    function automatic logic [5:0] model_small(input logic [71:0] d);
        int s;
        s = int'(d[3:0]) + int'(d[7:4]);
        return 6'(s);
    endfunction

    // Outputs and acceptances are sampled mid-cycle; they take effect at the
    // following rising edge.
    always @(negedge clk) begin
        if (rst) begin
            q0.delete(); q1.delete(); q2.delete();
        end else begin
            if (ov0) begin
                if (q0.size() == 0) check("u0_unexpected_valid", ov0, 0);
                else begin
                    check("u0_sum", sum0, q0[0]);
                    if (out_ready) void'(q0.pop_front());
                end
            end
            if (ov1) begin
                if (q1.size() == 0) check("u1_unexpected_valid", ov1, 0);
                else begin
                    check("u1_sum", sum1, q1[0]);
                    if (out_ready) void'(q1.pop_front());
                end
            end
            if (ov2) begin
                if (q2.size() == 0) check("u2_unexpected_valid", ov2, 0);
                else begin
                    check("u2_sum", sum2, q2[0]);
                    if (out_ready) void'(q2.pop_front());
                end
            end
            if (in_valid && rdy0) q0.push_back(cur_eu);
            if (in_valid && rdy1) q1.push_back(cur_es);
            if (in_valid && rdy2) q2.push_back(cur_esm);
        end
    end

    task automatic drive(input logic [71:0] d, input logic [11:0] eu, input logic [11:0] es,
                         input logic [5:0] esm);
        int  n   = 0;
        bit  acc = 1'b0;
        in_data  = d;
        cur_eu   = eu;
        cur_es   = es;
        cur_esm  = esm;
        in_valid = 1'b1;
        while (!acc) begin
            @(negedge clk);
            acc = rdy0;
            @(posedge clk);
            #1;
            n++;
            if (!acc && n > 200) begin
                check("drive_timeout", 64'(acc), 1);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drive_model(input logic [71:0] d);
        drive(d, model_u(d), model_s(d), model_small(d));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_out_valid(input string name);
        int n = 0;
        while (!ov0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(ov0), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        bit done;
        tbl[0] = '{8'hFF, 12'h8F7, 12'hFF7, 6'h1E};
        tbl[1] = '{8'h80, 12'h480, 12'hB80, 6'h08};
        tbl[2] = '{8'h01, 12'h009, 12'h009, 6'h01};
        tbl[3] = '{8'h7F, 12'h477, 12'h477, 6'h16};
        tbl[4] = '{8'h00, 12'h000, 12'h000, 6'h00};
        tbl[5] = '{8'hA5, 12'h5CD, 12'hCCD, 6'h0F};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
        cur_eu = '0; cur_es = '0; cur_esm = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", 64'(ov0), 0);
        check("rst_out_sum", 64'(sum0), 0);
        check("rst_in_ready", 64'(rdy0), 1);
        check("rst_small_valid", 64'(ov2), 0);
        check("rst_small_sum", 64'(sum2), 0);
        check("rst_small_ready", 64'(rdy2), 1);
        @(posedge clk); #1;

        // Latency: 2 cycles for the 9-input tree, 1 for the 2-input one
        drive({9{tbl[0].op}}, tbl[0].eu, tbl[0].es, tbl[0].esm);
        @(negedge clk);
        check("lat_first_cycle_valid", 64'(ov0), 0);
        check("lat_small_valid", 64'(ov2), 1);
        @(negedge clk);
        check("lat_second_cycle_valid", 64'(ov0), 1);
        idle(3);

        // Table of uniform operand patterns
        for (int i = 0; i < 6; i++) begin
            drive({9{tbl[i].op}}, tbl[i].eu, tbl[i].es, tbl[i].esm);
        end
        idle(4);

        // Back-to-back sets k=1..20 must emerge one per cycle
        fork
            begin
                for (int k = 1; k <= 20; k++) drive_model({9{8'(k)}});
            end
            begin
                wait_out_valid("b2b_first_valid");
                for (int i = 1; i < 20; i++) begin
                    @(negedge clk);
                    check("b2b_no_gap", 64'(ov0), 1);
                end
            end
        join
        idle(4);

        // Stall with full pipeline for 5 cycles
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) drive_model({9{8'(40 + 3 * i)}});
            end
            begin
                wait_out_valid("stall_fill_valid");
                for (int i = 0; i < 5; i++) begin
                    if (i > 0) @(negedge clk);
                    check("stall_in_ready", 64'(rdy0), 0);
                    check("stall_out_valid", 64'(ov0), 1);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        idle(5);

        // Random operands with random backpressure
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    logic [71:0] d;
                    d = {$urandom, $urandom, $urandom};
                    drive_model(d);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        idle(6);

        // Reset with two sets in flight: both must vanish
        out_ready = 1'b0;
        drive_model({9{8'h33}});
        drive_model({9{8'h44}});
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("flight_rst_out_valid", 64'(ov0), 0);
        check("flight_rst_out_sum", 64'(sum0), 0);
        check("flight_rst_in_ready", 64'(rdy0), 1);
        check("flight_rst_signed_sum", 64'(sum1), 0);
        check("flight_rst_small_valid", 64'(ov2), 0);
        out_ready = 1'b1;
        idle(6);

        // Everything accepted must have been emitted
        check("u0_drained", 64'(q0.size()), 0);
        check("u1_drained", 64'(q1.size()), 0);
        check("u2_drained", 64'(q2.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
